// File: rtl/disp_scan_ctrl.sv
// Six-digit multiplexed 7-segment scanner for the clock display.
// Latches hh:mm:ss once per frame and blinks the field being edited.
module disp_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       set_en,
    input  logic [1:0] blink_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_p
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [1:0]    sel_prev_q, sel_prev_d;
    logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_p_q, frame_p_d;

    logic       tick, frame_end, ghost, in_fld, blank;
    logic [3:0] nib;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        dig_d       = dig_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        sel_prev_d  = blink_sel;
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;

        tick       = (scan_cnt_q == SCAN_LAST);
        frame_end  = tick && (dig_q == 3'd5);
        scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;
        if (tick) begin
            dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
        end
        if (frame_end) begin
            hh_d = hh;
            mm_d = mm;
            ss_d = ss;
        end

        // A new field selection restarts the blink so it is seen at once.
        if (blink_sel != sel_prev_q) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        case (blink_sel)
            2'b00:   in_fld = (dig_q == 3'd0) || (dig_q == 3'd1);
            2'b01:   in_fld = (dig_q == 3'd2) || (dig_q == 3'd3);
            2'b10:   in_fld = (dig_q == 3'd4) || (dig_q == 3'd5);
            default: in_fld = 1'b0;
        endcase

        case (dig_q)
            3'd0:    nib = hh_q[7:4];
            3'd1:    nib = hh_q[3:0];
            3'd2:    nib = mm_q[7:4];
            3'd3:    nib = mm_q[3:0];
            3'd4:    nib = ss_q[7:4];
            default: nib = ss_q[3:0];
        endcase

        ghost     = (32'(scan_cnt_q) < BLANK_CYC);
        blank     = ghost || (set_en && blink_ph_q && in_fld);
        an_d      = blank ? '1 : ~(6'b000001 << dig_q);
        seg_d     = blank ? '1 : dec7(nib);
        dp_d      = !(((dig_q == 3'd1) || (dig_q == 3'd3)) && !blank);
        frame_p_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            dig_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            sel_prev_q  <= blink_sel;
            hh_q        <= '0;
            mm_q        <= '0;
            ss_q        <= '0;
            an_q        <= '1;
            seg_q       <= '1;
            dp_q        <= 1'b1;
            frame_p_q   <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            sel_prev_q  <= sel_prev_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_p_q   <= frame_p_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign frame_p = frame_p_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl against a cycle-count display model.
module tb_disp_scan_ctrl;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hh, mm, ss;
    logic       set_en;
    logic [1:0] blink_sel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_p;

    disp_scan_ctrl #(
        .SCAN_DIV(SD),
        .BLANK_CYC(BC),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hh(hh),
        .mm(mm),
        .ss(ss),
        .set_en(set_en),
        .blink_sel(blink_sel),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_p(frame_p)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: k counts cycles since reset release; base is when blink restarted.
    int         k = 0;
    int         base = 0;
    logic [1:0] prev_sel = 2'b11;
    logic [7:0] sh_hh = 0, sh_mm = 0, sh_ss = 0;
    logic [6:0] dec_tbl [16];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h k=%0d", tag, got, exp, k);
        end
    endtask

    function automatic int ph_now();
        return ((k - base) / BD) % 2;
    endfunction

    task automatic cycle_step();
        logic [5:0] e_an, one;
        logic [6:0] e_seg;
        logic       e_dp, e_fp, blank;
        logic [7:0] byte_v;
        logic [3:0] nib;
        int pos, dg;
        if (rst) begin
            e_an = '1; e_seg = '1; e_dp = 1'b1; e_fp = 1'b0;
        end else begin
            pos = k % SD;
            dg  = (k / SD) % 6;
            blank = (pos < BC) ||
                    (set_en && blink_sel != 2'b11 && ph_now() == 1 &&
                     (dg / 2) == int'(blink_sel));
            byte_v = (dg < 2) ? sh_hh : (dg < 4) ? sh_mm : sh_ss;
            nib = (dg % 2 == 0) ? byte_v[7:4] : byte_v[3:0];
            one = 6'(1 << dg);
            e_an  = blank ? 6'h3f : ~one;
            e_seg = blank ? 7'h7f : dec_tbl[nib];
            e_dp  = ((dg == 1 || dg == 3) && !blank) ? 1'b0 : 1'b1;
            e_fp  = (pos == SD - 1) && (dg == 5);
        end
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_p", 32'(frame_p), 32'(e_fp));
        if (rst) begin
            k = 0; base = 0; prev_sel = blink_sel;
            sh_hh = 0; sh_mm = 0; sh_ss = 0;
        end else begin
            if (e_fp) begin
                sh_hh = hh; sh_mm = mm; sh_ss = ss;
            end
            if (blink_sel != prev_sel) base = k + 1;
            prev_sel = blink_sel;
            k++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_step();
    endtask

    initial begin
        dec_tbl[0] = 7'b1000000; dec_tbl[1] = 7'b1111001;
        dec_tbl[2] = 7'b0100100; dec_tbl[3] = 7'b0110000;
        dec_tbl[4] = 7'b0011001; dec_tbl[5] = 7'b0010010;
        dec_tbl[6] = 7'b0000010; dec_tbl[7] = 7'b1111000;
        dec_tbl[8] = 7'b0000000; dec_tbl[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) dec_tbl[i] = 7'b0111111;

        rst = 1'b1;
        hh = 8'($urandom); mm = 8'($urandom); ss = 8'($urandom);
        set_en = 1'($urandom); blink_sel = 2'b11;
        run(3);

        rst = 1'b0;
        hh = 8'h12; mm = 8'h34; ss = 8'h56; set_en = 1'b0;
        run(24);
        chk("first_frame_p", 32'(frame_p), 32'd1);
        run(32);

        while ((k % (6 * SD)) / SD != 2) cycle_step();
        mm = 8'h59;
        run(60);

        set_en = 1'b1; blink_sel = 2'b01;
        run(48);
        blink_sel = 2'b11;
        run(30);

        blink_sel = 2'b01;
        run(2);
        for (int i = 0; i < 40 && ph_now() != 1; i++) cycle_step();
        chk("ph_wait", 32'(ph_now()), 32'd1);
        blink_sel = 2'b10;
        run(40);

        ss = 8'h5A; set_en = 1'b0;
        run(36);
        while (k % SD != 2) cycle_step();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(36);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) hh = 8'($urandom);
            if ($urandom_range(0, 19) == 0) mm = 8'($urandom);
            if ($urandom_range(0, 19) == 0) ss = 8'($urandom);
            if ($urandom_range(0, 99) == 0) set_en = ~set_en;
            if ($urandom_range(0, 29) == 0) blink_sel = 2'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            cycle_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
